// File: rtl/sockit_spi_pkg.sv
// Shared constants and types for the SPI command-port arbiter.
// Field positions of the command control word and the arbiter FSM state type.
package sockit_spi_pkg;

    localparam int CTL_CKE = 0;
    localparam int CTL_SSO = 1;
    localparam int CTL_DOE = 2;
    localparam int CTL_DIE = 3;
    localparam int CTL_IOM = 4;
    localparam int CTL_PKM = 6;
    localparam int CTL_LEN = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    // One-hot owner vector as seen on arb_gnt
    function automatic logic [1:0] gnt_of(arb_state_t s);
        return {s == OWN1, s == OWN0};
    endfunction

endpackage

// File: rtl/sockit_spi_arb_if.sv
// Valid/ready command channel (ctl + data) between a requester and the SPI datapath.
// The producer of a command uses the master modport, the consumer the slave modport.
interface sockit_spi_arb_if #(
    parameter int CCO = 12,
    parameter int CDW = 32
);
    logic           vld;
    logic [CCO-1:0] ctl;
    logic [CDW-1:0] dat;
    logic           rdy;

    modport master (output vld, ctl, dat, input rdy);
    modport slave  (input vld, ctl, dat, output rdy);
endinterface

// File: rtl/sockit_spi_arb_tmr.sv
// Idle-owner timeout counter for the arbiter lock (used with SOCKIT_SPI_ARB_TMO_EN).
// done_o fires in the TMO-th consecutive incrementing cycle since the last clear.
module sockit_spi_arb_tmr #(
    parameter int TMO = 256,
    parameter int TMW = $clog2(TMO + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic inc_i,
    output logic done_o
);
    logic [TMW-1:0] cnt_q, cnt_d;

    assign done_o = inc_i && (cnt_q == TMW'(TMO - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (inc_i)
            cnt_d = cnt_q + TMW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end
endmodule

// File: rtl/sockit_spi_arb.sv
// Two-requester lock arbiter in front of the SPI command port; the owner keeps the
// grant until it transfers a command with sso=0. Optional timeout: SOCKIT_SPI_ARB_TMO_EN.
module sockit_spi_arb
    import sockit_spi_pkg::*;
#(
    parameter int CCO = 12,
    parameter int CDW = 32,
    parameter int TMO = 256,
    parameter int TMW = $clog2(TMO + 1)
) (
    input  logic             clk,
    input  logic             rst,
    sockit_spi_arb_if.slave  r0,
    sockit_spi_arb_if.slave  r1,
    sockit_spi_arb_if.master cmd,
    output logic [1:0]       arb_gnt,
    output logic             arb_tmo
);
    arb_state_t     state_q, state_d;
    logic           ptr_q, ptr_d;
    logic           own_vld;
    logic [CCO-1:0] own_ctl;
    logic [CDW-1:0] own_dat;
    logic           trn, rel, tmo_done;

    // Owner's channel is passed straight through; nothing is registered on the data path
    always_comb begin
        own_vld = 1'b0;
        own_ctl = '0;
        own_dat = '0;
        case (state_q)
            OWN0: begin
                own_vld = r0.vld;
                own_ctl = r0.ctl;
                own_dat = r0.dat;
            end
            OWN1: begin
                own_vld = r1.vld;
                own_ctl = r1.ctl;
                own_dat = r1.dat;
            end
            default: ;
        endcase
    end

    assign cmd.vld = own_vld;
    assign cmd.ctl = own_ctl;
    assign cmd.dat = own_dat;
    assign r0.rdy  = (state_q == OWN0) && cmd.rdy;
    assign r1.rdy  = (state_q == OWN1) && cmd.rdy;
    assign arb_gnt = gnt_of(state_q);

    assign trn = own_vld && cmd.rdy;
    assign rel = trn && !own_ctl[CTL_SSO];

    // Release always passes through IDLE, so a waiting requester is granted one cycle later
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (r0.vld && r1.vld)
                    state_d = ptr_q ? OWN1 : OWN0;
                else if (r0.vld)
                    state_d = OWN0;
                else if (r1.vld)
                    state_d = OWN1;
            end
            OWN0, OWN1: begin
                if (rel || tmo_done) begin
                    state_d = IDLE;
                    ptr_d   = (state_q == OWN0);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

`ifdef SOCKIT_SPI_ARB_TMO_EN
    logic tmo_q;

    // Counter is held clear in IDLE, so it starts from zero on every new grant
    sockit_spi_arb_tmr #(
        .TMO (TMO),
        .TMW (TMW)
    ) u_tmr (
        .clk    (clk),
        .rst    (rst),
        .clr_i  ((state_q == IDLE) || trn),
        .inc_i  ((state_q != IDLE) && !own_vld),
        .done_o (tmo_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            tmo_q <= 1'b0;
        else
            tmo_q <= tmo_done;
    end

    assign arb_tmo = tmo_q;
`else
    assign tmo_done = 1'b0;
    assign arb_tmo  = 1'b0;
`endif
endmodule
